// File: rtl/audio_stats_pkg.sv
// audio_stats_pkg: state enum, default parameters and width helpers for audio_stats_mon (no ports)
package audio_stats_pkg;
   typedef enum logic {IDLE, ACCUM} state_t;
   localparam int DEF_NUM_CH   = 2;
   localparam int DEF_SMPL_W   = 16;
   localparam int DEF_LOG2_WIN = 10;
   function automatic int sum_w(input int smpl_w, input int log2_win);
      return smpl_w + log2_win;
   endfunction
   function automatic int xing_w(input int log2_win);
      return log2_win + 1;
   endfunction
endpackage

// File: rtl/audio_stats_if.sv
// audio_stats_if: sample input and window result bundle; master drives samples, slave (monitor) returns stats; clip_out exists only with AUDIO_STATS_CLIP_EN
interface audio_stats_if
   import audio_stats_pkg::*;
#(
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int SMPL_W   = DEF_SMPL_W,
   parameter int LOG2_WIN = DEF_LOG2_WIN
);
   logic                                 smpl_vld;
   logic [NUM_CH*SMPL_W-1:0]             smpl_in;
   logic                                 clr;
   logic                                 stats_vld;
   logic [NUM_CH*SMPL_W-1:0]             max_out;
   logic [NUM_CH*SMPL_W-1:0]             min_out;
   logic [NUM_CH*SMPL_W-1:0]             avg_out;
   logic [NUM_CH*xing_w(LOG2_WIN)-1:0]   xing_out;
`ifdef AUDIO_STATS_CLIP_EN
   logic [NUM_CH-1:0]                    clip_out;
   modport master (output smpl_vld, smpl_in, clr,
                   input  stats_vld, max_out, min_out, avg_out, xing_out, clip_out);
   modport slave  (input  smpl_vld, smpl_in, clr,
                   output stats_vld, max_out, min_out, avg_out, xing_out, clip_out);
`else
   modport master (output smpl_vld, smpl_in, clr,
                   input  stats_vld, max_out, min_out, avg_out, xing_out);
   modport slave  (input  smpl_vld, smpl_in, clr,
                   output stats_vld, max_out, min_out, avg_out, xing_out);
`endif
endinterface

// File: rtl/audio_stats_chan.sv
// audio_stats_chan: per-channel window max/min/mean/zero-crossing datapath
// Ports: clk, rst_n (async active-low); acc = sample accepted, first/last = window position,
// have_prev = a previous sample exists for crossing detection; smpl = signed sample;
// max_out/min_out/avg_out/xing_out = latched window results; clip_out with AUDIO_STATS_CLIP_EN
module audio_stats_chan
   import audio_stats_pkg::*;
#(
   parameter int SMPL_W   = DEF_SMPL_W,
   parameter int LOG2_WIN = DEF_LOG2_WIN
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              acc,
   input  logic                              first,
   input  logic                              last,
   input  logic                              have_prev,
   input  logic signed [SMPL_W-1:0]          smpl,
   output logic signed [SMPL_W-1:0]          max_out,
   output logic signed [SMPL_W-1:0]          min_out,
   output logic signed [SMPL_W-1:0]          avg_out,
   output logic [xing_w(LOG2_WIN)-1:0]       xing_out
`ifdef AUDIO_STATS_CLIP_EN
   ,
   output logic                              clip_out
`endif
);
   localparam int SW = sum_w(SMPL_W, LOG2_WIN);
   localparam int XW = xing_w(LOG2_WIN);
   logic signed [SMPL_W-1:0] max_r, min_r, max_nx, min_nx, avg_nx;
   logic signed [SW-1:0]     sum_r, sum_nx, smpl_ext;
   logic [XW-1:0]            xing_r, xing_nx;
   logic                     prev_sign, xing;
`ifdef AUDIO_STATS_CLIP_EN
   logic                     clip_r, clip_nx;
`endif
   // Next-window-state includes the current sample so the last sample lands in the latched result
   always_comb begin
      smpl_ext = SW'(smpl);
      xing     = have_prev && (smpl[SMPL_W-1] != prev_sign);
      max_nx   = (first || smpl > max_r) ? smpl : max_r;
      min_nx   = (first || smpl < min_r) ? smpl : min_r;
      sum_nx   = first ? smpl_ext : sum_r + smpl_ext;
      xing_nx  = (first ? '0 : xing_r) + XW'(xing);
      avg_nx   = SMPL_W'(sum_nx >>> LOG2_WIN);
`ifdef AUDIO_STATS_CLIP_EN
      clip_nx  = (!first && clip_r) || smpl == {1'b0, {(SMPL_W-1){1'b1}}}
                                    || smpl == {1'b1, {(SMPL_W-1){1'b0}}};
`endif
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         max_r     <= '0;
         min_r     <= '0;
         sum_r     <= '0;
         xing_r    <= '0;
         prev_sign <= 1'b0;
         max_out   <= '0;
         min_out   <= '0;
         avg_out   <= '0;
         xing_out  <= '0;
`ifdef AUDIO_STATS_CLIP_EN
         clip_r    <= 1'b0;
         clip_out  <= 1'b0;
`endif
      end else if (acc) begin
         max_r     <= max_nx;
         min_r     <= min_nx;
         sum_r     <= sum_nx;
         xing_r    <= xing_nx;
         prev_sign <= smpl[SMPL_W-1];
`ifdef AUDIO_STATS_CLIP_EN
         clip_r    <= clip_nx;
`endif
         if (last) begin
            max_out  <= max_nx;
            min_out  <= min_nx;
            avg_out  <= avg_nx;
            xing_out <= xing_nx;
`ifdef AUDIO_STATS_CLIP_EN
            clip_out <= clip_nx;
`endif
         end
      end
endmodule

// File: rtl/audio_stats_mon.sv
// audio_stats_mon: multi-channel audio window statistics monitor (max/min/mean/zero crossings)
// Ports: clk, rst_n (async active-low); bus = audio_stats_if.slave carrying smpl_vld/smpl_in/clr
// in and stats_vld/max_out/min_out/avg_out/xing_out out; clip_out added with AUDIO_STATS_CLIP_EN
// Requires LOG2_WIN >= 1.
module audio_stats_mon
   import audio_stats_pkg::*;
#(
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int SMPL_W   = DEF_SMPL_W,
   parameter int LOG2_WIN = DEF_LOG2_WIN
) (
   input  logic          clk,
   input  logic          rst_n,
   audio_stats_if.slave  bus
);
   localparam int XW = xing_w(LOG2_WIN);
   state_t                   state, state_nx;
   logic [LOG2_WIN-1:0]      cnt;
   logic                     acc, first, last, have_prev, vld_r;
   logic [NUM_CH*SMPL_W-1:0] max_v, min_v, avg_v;
   logic [NUM_CH*XW-1:0]     xing_v;
`ifdef AUDIO_STATS_CLIP_EN
   logic [NUM_CH-1:0]        clip_v;
`endif
   assign acc       = bus.smpl_vld && !bus.clr;
   assign first     = cnt == '0;
   assign last      = &cnt;
   assign have_prev = state == ACCUM;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_comb begin
      state_nx = state;
      state_nx = bus.clr ? IDLE : acc ? ACCUM : state;
   end
   // clr drops the partial window silently: counter restarts and no pulse is raised
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt   <= '0;
         vld_r <= 1'b0;
      end else begin
         cnt   <= bus.clr ? '0 : acc ? cnt + LOG2_WIN'(1) : cnt;
         vld_r <= acc && last;
      end
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      audio_stats_chan #(.SMPL_W(SMPL_W), .LOG2_WIN(LOG2_WIN)) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .acc       (acc),
         .first     (first),
         .last      (last),
         .have_prev (have_prev),
         .smpl      (bus.smpl_in[k*SMPL_W +: SMPL_W]),
         .max_out   (max_v[k*SMPL_W +: SMPL_W]),
         .min_out   (min_v[k*SMPL_W +: SMPL_W]),
         .avg_out   (avg_v[k*SMPL_W +: SMPL_W]),
         .xing_out  (xing_v[k*XW +: XW])
`ifdef AUDIO_STATS_CLIP_EN
         ,
         .clip_out  (clip_v[k])
`endif
      );
   end
   assign bus.stats_vld = vld_r;
   assign bus.max_out   = max_v;
   assign bus.min_out   = min_v;
   assign bus.avg_out   = avg_v;
   assign bus.xing_out  = xing_v;
`ifdef AUDIO_STATS_CLIP_EN
   assign bus.clip_out  = clip_v;
`endif
endmodule

// File: doc/audio_stats_mon.md
AUDIO_STATS_MON -- requirements
Module: audio_stats_mon

Interface
REQ-001 Parameter NUM_CH, default 2, number of audio channels (1..8).
REQ-002 Parameter SMPL_W, default 16, signed sample width in bits.
REQ-003 Parameter LOG2_WIN, default 10, log2 of the window length in samples (window = 2^LOG2_WIN).
REQ-004 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 smpl_vld  in  1  one-cycle strobe; when high, smpl_in holds one sample set.
REQ-007 smpl_in  in  NUM_CH*SMPL_W  signed samples; channel k occupies bits [k*SMPL_W +: SMPL_W].
REQ-008 clr  in  1  synchronous restart of the window.
REQ-009 stats_vld  out  1  one-cycle pulse; result outputs are updated.
REQ-010 max_out, min_out, avg_out  out  NUM_CH*SMPL_W each  per-channel signed window maximum, minimum and mean.
REQ-011 xing_out  out  NUM_CH*(LOG2_WIN+1)  per-channel zero-crossing count.

Function
REQ-012 A sample set SHALL be accepted on every cycle where smpl_vld=1 and clr=0.
REQ-013 The FSM SHALL have two states. IDLE means no previous sample is held. ACCUM means a previous sample is held. IDLE->ACCUM on the first accepted sample; ACCUM->IDLE only on clr or reset.
REQ-014 A window counter SHALL count accepted samples from 0 to 2^LOG2_WIN-1 and wrap to 0.
REQ-015 On the first sample of a window (count=0), each channel's max, min and sum SHALL load that sample and its crossing count SHALL be 0 (or 1 if that sample crosses, per REQ-018).
REQ-016 On later samples: max and min update by signed compare; sum accumulates in SMPL_W+LOG2_WIN signed bits with no overflow possible.
REQ-017 On the last sample (count=2^LOG2_WIN-1), outputs SHALL latch the stats including that sample, and stats_vld SHALL pulse on the following cycle (latency of 1 cycle).
REQ-018 A crossing SHALL be counted when the sign bit of the current sample differs from that of the previous sample; zero counts as non-negative.
REQ-019 Crossings SHALL be counted across window boundaries, against the last sample of the prior window; no crossing SHALL be counted in IDLE.
REQ-020 avg_out SHALL equal sum >>> LOG2_WIN (arithmetic shift, floor), truncated to SMPL_W bits.
REQ-021 Outputs SHALL hold their values between windows.
REQ-022 Back-to-back smpl_vld on every cycle SHALL be supported with no dropped samples.
REQ-023 When clr=1: the FSM goes to IDLE, the window counter goes to 0, outputs are retained, and no stats_vld is issued for the partial window.
REQ-024 If clr and smpl_vld are high in the same cycle, clr wins and the sample is discarded.

Reset
REQ-025 On rst_n low, all outputs SHALL go to 0, the FSM to IDLE and the counters to 0, immediately and regardless of the clock.
REQ-026 Reset mid-window SHALL discard the partial window with no stats_vld.

Configuration
REQ-027 With AUDIO_STATS_CLIP_EN defined, the block SHALL add output clip_out (NUM_CH bits), latched with the other results.
REQ-028 clip_out[k] SHALL be set if any sample of channel k in the window equals the most positive or most negative SMPL_W value; its reset value is 0.
REQ-029 Without AUDIO_STATS_CLIP_EN, the clip_out port and its logic SHALL be absent and all other behaviour is unchanged.

Structure
REQ-030 Package audio_stats_pkg SHALL hold the FSM state enum, the default parameter constants, and width helper functions (sum width, crossing width).
REQ-031 Per-channel datapath SHALL live in sub-module audio_stats_chan, generated NUM_CH times; the FSM and window counter stay in audio_stats_mon.

Verification (NUM_CH=2, SMPL_W=16, LOG2_WIN=3)
REQ-032 Reset asserted -> all outputs are 0 and stats_vld is 0.
REQ-033 Ch0 samples 100,-50,200,-300,0,5,-5,10 -> one cycle after the 8th sample, stats_vld=1 and max=200, min=-300, avg=-5 (sum -40), xing=6.
REQ-034 Ch1 samples 32767 x8 -> max=min=avg=32767, xing=0; clip_out[1]=1 when AUDIO_STATS_CLIP_EN is defined.
REQ-035 Five samples, then clr, then 8 new samples -> a single stats_vld, with results from the 8 new samples only.
REQ-036 smpl_vld held high for 16 cycles, with the sign flipping between the 8th and 9th samples -> stats_vld at cycles 9 and 17, and the boundary crossing counted in the second window.
REQ-037 rst_n pulsed low after 4 samples -> outputs are 0 immediately; the next full window reports correctly.
